// File: rtl/dds_cmd_decoder_pkg.sv
// Shared opcodes, payload lengths, FSM encoding and frame context for the DDS command decoder.
// Pure definitions: no latency and no backpressure of its own.
package dds_cmd_decoder_pkg;

  localparam logic [7:0] OP_FREQ  = 8'h46;
  localparam logic [7:0] OP_PHASE = 8'h50;
  localparam logic [7:0] OP_WRITE = 8'h57;

  localparam logic [2:0] LEN_FREQ  = 3'd4;
  localparam logic [2:0] LEN_PHASE = 3'd2;
  localparam logic [2:0] LEN_WRITE = 3'd3;

  localparam logic [8:0] PHASE_MAX = 9'd359;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PAYLOAD = 3'd1,
    S_CHECK   = 3'd2,
    S_EXEC    = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  // In-flight frame context, captured from the opcode byte onward.
  typedef struct packed {
    logic [7:0]  op;
    logic [2:0]  cnt;
    logic [7:0]  csum;
    logic [31:0] stage;
  } frame_t;

  // A zero length marks a byte that is not a known opcode.
  function automatic logic [2:0] payload_len(input logic [7:0] op);
    case (op)
      OP_FREQ:  payload_len = LEN_FREQ;
      OP_PHASE: payload_len = LEN_PHASE;
      OP_WRITE: payload_len = LEN_WRITE;
      default:  payload_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dds_cmd_decoder_timeout.sv
// Saturating idle counter: cleared by clr, counts while en; expired is high while saturated and enabled.
// Zero-latency combinational terminal flag; no backpressure.
module frame_timeout #(
  parameter int unsigned LIMIT = 50000
) (
  input  logic src_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // An accepted byte in the same cycle always beats the timeout.
  assign expired = en && !clr && (cnt == LIM);

endmodule

// File: rtl/dds_cmd_decoder.sv
// Framed byte-stream decoder: opcode + payload + XOR checksum -> one freq/phase/table-write strobe.
// Strobe one cycle after the checksum byte; in_ready drops only for the single EXEC/ERR cycle.
module dds_cmd_decoder
  import dds_cmd_decoder_pkg::*;
#(
  parameter int DATA_LEN    = 11,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                src_clk,
  input  logic                rst_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                set_freq,
  output logic [31:0]         freq,
  output logic                set_phase,
  output logic [8:0]          phase,
  output logic                we,
  output logic [ADDR_W-1:0]   addr_wr,
  output logic [DATA_LEN-1:0] data_wr,
  output logic                frame_ok,
  output logic                frame_err
);

  state_t state;
  frame_t frm;
  logic   accept;
  logic   tmo_en;
  logic   tmo;
  logic   phase_ok;

  assign accept   = in_valid && in_ready;
  assign tmo_en   = (state == S_PAYLOAD) || (state == S_CHECK);
  assign phase_ok = (frm.stage[8:0] <= PHASE_MAX);

  frame_timeout #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .src_clk (src_clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (tmo_en),
    .expired (tmo)
  );

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      frm       <= '0;
      in_ready  <= 1'b1;
      set_freq  <= 1'b0;
      freq      <= '0;
      set_phase <= 1'b0;
      phase     <= '0;
      we        <= 1'b0;
      addr_wr   <= '0;
      data_wr   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      set_freq  <= 1'b0;
      set_phase <= 1'b0;
      we        <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            if (payload_len(in_data) != 3'd0) begin
              frm.op    <= in_data;
              frm.cnt   <= payload_len(in_data);
              frm.csum  <= in_data;
              frm.stage <= '0;
              state     <= S_PAYLOAD;
            end else begin
              frame_err <= 1'b1;
              in_ready  <= 1'b0;
              state     <= S_ERR;
            end
          end
        end

        S_PAYLOAD: begin
          if (accept) begin
            frm.stage <= {frm.stage[23:0], in_data};
            frm.csum  <= frm.csum ^ in_data;
            frm.cnt   <= frm.cnt - 3'd1;
            if (frm.cnt == 3'd1) state <= S_CHECK;
          end else if (tmo) begin
            frame_err <= 1'b1;
            in_ready  <= 1'b0;
            state     <= S_ERR;
          end
        end

        S_CHECK: begin
          if (accept) begin
            // Out-of-range phase is rejected here so the phase register never sees it.
            if ((in_data == frm.csum) && ((frm.op != OP_PHASE) || phase_ok)) begin
              frame_ok <= 1'b1;
              in_ready <= 1'b0;
              state    <= S_EXEC;
              case (frm.op)
                OP_FREQ: begin
                  freq     <= frm.stage;
                  set_freq <= 1'b1;
                end
                OP_PHASE: begin
                  phase     <= frm.stage[8:0];
                  set_phase <= 1'b1;
                end
                OP_WRITE: begin
                  addr_wr <= frm.stage[16 +: ADDR_W];
                  data_wr <= frm.stage[DATA_LEN-1:0];
                  we      <= 1'b1;
                end
                default: ;
              endcase
            end else begin
              frame_err <= 1'b1;
              in_ready  <= 1'b0;
              state     <= S_ERR;
            end
          end else if (tmo) begin
            frame_err <= 1'b1;
            in_ready  <= 1'b0;
            state     <= S_ERR;
          end
        end

        S_EXEC, S_ERR: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end

        default: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_cmd_decoder.sv
// Directed bench for dds_cmd_decoder: hand-computed frames, strobe timing and error paths.
module tb_dds_cmd_decoder;

  localparam int TMO = 40;

  logic        src_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        set_freq;
  logic [31:0] freq;
  logic        set_phase;
  logic [8:0]  phase;
  logic        we;
  logic [7:0]  addr_wr;
  logic [10:0] data_wr;
  logic        frame_ok;
  logic        frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_freq = 0;
  int n_phase = 0;
  int n_we = 0;
  int n_excl = 0;

  dds_cmd_decoder #(
    .DATA_LEN(11),
    .ADDR_W(8),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .src_clk   (src_clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .set_freq  (set_freq),
    .freq      (freq),
    .set_phase (set_phase),
    .phase     (phase),
    .we        (we),
    .addr_wr   (addr_wr),
    .data_wr   (data_wr),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  always #5 src_clk = ~src_clk;

  always @(posedge src_clk) cyc <= cyc + 1;

  always @(negedge src_clk) begin
    if (set_freq)  n_freq  <= n_freq + 1;
    if (set_phase) n_phase <= n_phase + 1;
    if (we)        n_we    <= n_we + 1;
    if ((int'(set_freq) + int'(set_phase) + int'(we)) > 1) n_excl <= n_excl + 1;
  end

  // Returns just after the accepting edge (+1), with the cycle index of that edge.
  task automatic send_byte(input logic [7:0] b, output int acc);
    int waited;
    waited = 0;
    @(negedge src_clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(negedge src_clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL handshake byte %h: in_ready=%b after %0d cycles, need 1", b, in_ready, waited);
      in_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge src_clk);
      acc = cyc;
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge src_clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
    total++; if ({set_freq, set_phase, we, frame_ok, frame_err} !== 5'b0) begin bad++; $display("FAIL reset_strobes: got %b need 00000", {set_freq, set_phase, we, frame_ok, frame_err}); end
    total++; if ({freq, phase, addr_wr, data_wr} !== '0) begin bad++; $display("FAIL reset_data: freq=%h phase=%0d addr=%h data=%h need 0", freq, phase, addr_wr, data_wr); end
    rst_n = 1'b1;
    @(posedge src_clk); #1;
    total++; if ({set_freq, set_phase, we, frame_ok, frame_err, in_ready} !== 6'b000001) begin bad++; $display("FAIL reset_release: got %b need 000001", {set_freq, set_phase, we, frame_ok, frame_err, in_ready}); end
  endtask

  task automatic test_freq();
    int a;
    send_byte(8'h46, a); send_byte(8'h00, a); send_byte(8'h00, a);
    send_byte(8'h03, a); send_byte(8'hE8, a); send_byte(8'hAD, a);
    total++; if (set_freq !== 1'b1) begin bad++; $display("FAIL freq_strobe: got %b need 1", set_freq); end
    total++; if (freq !== 32'd1000) begin bad++; $display("FAIL freq_value: got %0d need 1000", freq); end
    total++; if (frame_ok !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL freq_ok: ok=%b err=%b need 1/0", frame_ok, frame_err); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL freq_exec_ready: got %b need 0", in_ready); end
    @(posedge src_clk); #1;
    total++; if (set_freq !== 1'b0 || in_ready !== 1'b1 || freq !== 32'd1000) begin bad++; $display("FAIL freq_after: strobe=%b ready=%b freq=%0d need 0/1/1000", set_freq, in_ready, freq); end
  endtask

  task automatic test_phase();
    int a;
    send_byte(8'h50, a); send_byte(8'h00, a); send_byte(8'h5A, a); send_byte(8'h0A, a);
    total++; if (set_phase !== 1'b1 || phase !== 9'd90) begin bad++; $display("FAIL phase_90: strobe=%b phase=%0d need 1/90", set_phase, phase); end
    @(posedge src_clk); #1;
    send_byte(8'h50, a); send_byte(8'h01, a); send_byte(8'h68, a); send_byte(8'h39, a);
    total++; if (frame_err !== 1'b1 || frame_ok !== 1'b0) begin bad++; $display("FAIL phase_360_err: err=%b ok=%b need 1/0", frame_err, frame_ok); end
    total++; if (set_phase !== 1'b0 || phase !== 9'd90) begin bad++; $display("FAIL phase_360_hold: strobe=%b phase=%0d need 0/90", set_phase, phase); end
    @(posedge src_clk); #1;
  endtask

  task automatic test_write();
    int a;
    int w0;
    w0 = n_we;
    send_byte(8'h57, a); send_byte(8'h10, a); send_byte(8'h03, a);
    send_byte(8'hF5, a); send_byte(8'hB1, a);
    total++; if (we !== 1'b1 || addr_wr !== 8'h10 || data_wr !== 11'h3F5) begin bad++; $display("FAIL write: we=%b addr=%h data=%h need 1/10/3f5", we, addr_wr, data_wr); end
    total++; if (set_freq !== 1'b0 || set_phase !== 1'b0) begin bad++; $display("FAIL write_excl: freq=%b phase=%b need 0/0", set_freq, set_phase); end
    repeat (3) @(posedge src_clk); #1;
    total++; if (n_we - w0 !== 1) begin bad++; $display("FAIL write_pulses: got %0d need 1", n_we - w0); end
  endtask

  task automatic test_bad_frames();
    int a;
    send_byte(8'h46, a); send_byte(8'h00, a); send_byte(8'h00, a);
    send_byte(8'h03, a); send_byte(8'hE8, a); send_byte(8'h00, a);
    total++; if (frame_err !== 1'b1 || set_freq !== 1'b0 || freq !== 32'd1000) begin bad++; $display("FAIL bad_csum: err=%b strobe=%b freq=%0d need 1/0/1000", frame_err, set_freq, freq); end
    @(posedge src_clk); #1;
    send_byte(8'h41, a);
    total++; if (frame_err !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bad_opcode: err=%b ready=%b need 1/0", frame_err, in_ready); end
    @(posedge src_clk); #1;
    total++; if (frame_err !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bad_opcode_after: err=%b ready=%b need 0/1", frame_err, in_ready); end
  endtask

  task automatic test_back_to_back();
    int a;
    int c;
    int o;
    send_byte(8'h46, a); send_byte(8'h12, a); send_byte(8'h34, a);
    send_byte(8'h56, a); send_byte(8'h78, a); send_byte(8'h4E, c);
    total++; if (set_freq !== 1'b1 || freq !== 32'h12345678) begin bad++; $display("FAIL b2b_freq: strobe=%b freq=%h need 1/12345678", set_freq, freq); end
    send_byte(8'h50, o);
    total++; if (o - c !== 2) begin bad++; $display("FAIL b2b_gap: opcode %0d cycles after checksum, need 2", o - c); end
    send_byte(8'h01, a); send_byte(8'h67, a); send_byte(8'h36, a);
    total++; if (set_phase !== 1'b1 || phase !== 9'd359) begin bad++; $display("FAIL b2b_phase_359: strobe=%b phase=%0d need 1/359", set_phase, phase); end
    @(posedge src_clk); #1;
  endtask

  task automatic test_timeout();
    int a;
    int seen;
    seen = -1;
    send_byte(8'h46, a); send_byte(8'h12, a);
    for (int k = 1; k <= TMO + 10; k++) begin
      @(posedge src_clk); #1;
      if (frame_err) begin
        seen = k;
        break;
      end
    end
    total++; if (seen !== TMO + 1) begin bad++; $display("FAIL timeout_cycle: err after %0d cycles, need %0d", seen, TMO + 1); end
    total++; if (freq !== 32'h12345678) begin bad++; $display("FAIL timeout_freq_hold: got %h need 12345678", freq); end
    send_byte(8'h50, a); send_byte(8'h00, a); send_byte(8'h2D, a); send_byte(8'h7D, a);
    total++; if (set_phase !== 1'b1 || phase !== 9'd45) begin bad++; $display("FAIL timeout_recover: strobe=%b phase=%0d need 1/45", set_phase, phase); end
    @(posedge src_clk); #1;
  endtask

  task automatic test_reset_midframe();
    int a;
    int w0;
    w0 = n_we;
    send_byte(8'h57, a); send_byte(8'h10, a); send_byte(8'h03, a);
    @(negedge src_clk);
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || {set_freq, set_phase, we, frame_ok, frame_err} !== 5'b0) begin bad++; $display("FAIL midrst_ctrl: ready=%b strobes=%b need 1/00000", in_ready, {set_freq, set_phase, we, frame_ok, frame_err}); end
    total++; if ({freq, phase, addr_wr, data_wr} !== '0) begin bad++; $display("FAIL midrst_data: freq=%h phase=%0d addr=%h data=%h need 0", freq, phase, addr_wr, data_wr); end
    @(negedge src_clk);
    rst_n = 1'b1;
    send_byte(8'h57, a); send_byte(8'h10, a); send_byte(8'h03, a);
    send_byte(8'hF5, a); send_byte(8'hB1, a);
    total++; if (we !== 1'b1 || data_wr !== 11'h3F5 || addr_wr !== 8'h10) begin bad++; $display("FAIL midrst_resend: we=%b addr=%h data=%h need 1/10/3f5", we, addr_wr, data_wr); end
    repeat (3) @(posedge src_clk); #1;
    total++; if (n_we - w0 !== 1) begin bad++; $display("FAIL midrst_pulses: got %0d need 1", n_we - w0); end
  endtask

  task automatic test_totals();
    total++; if (n_excl !== 0) begin bad++; $display("FAIL mutex: %0d overlapping strobe cycles, need 0", n_excl); end
    total++; if (n_freq !== 2) begin bad++; $display("FAIL freq_count: got %0d need 2", n_freq); end
    total++; if (n_phase !== 3) begin bad++; $display("FAIL phase_count: got %0d need 3", n_phase); end
    total++; if (n_we !== 2) begin bad++; $display("FAIL we_count: got %0d need 2", n_we); end
  endtask

  initial begin
    test_reset();
    test_freq();
    test_phase();
    test_write();
    test_bad_frames();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    test_totals();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
